// File: rtl/sha1_msg_schedule_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sha1_msg_schedule_ctrl_pkg
//   Shared types and constants for the SHA-1 message schedule sequencer.
//   Contents:
//     sched_state_t        - controller FSM states (IDLE, LOAD, RUN)
//     SHA1_WORDS_PER_BLOCK - 32-bit words per 512-bit block (16)
//     SHA1_ROUNDS          - schedule words per block in standard SHA-1 (80)
//     word_t               - 32-bit message/schedule word
//     rotl1()              - rotate-left-by-one used by the schedule recurrence
// ----------------------------------------------------------------------------
package sha1_msg_schedule_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

    localparam int SHA1_WORDS_PER_BLOCK = 16;
    localparam int SHA1_ROUNDS          = 80;

    typedef logic [31:0] word_t;

    function automatic word_t rotl1(input word_t w);
        return {w[30:0], w[31]};
    endfunction

endpackage

// File: rtl/sha1_msg_schedule_ctrl_new_block.sv
// ----------------------------------------------------------------------------
// sha1_new_block
//   Combinational SHA-1 schedule generator:
//     w_new = rotl1(w_m3 ^ w_m8 ^ w_m14 ^ w_m16)
//   Ports:
//     w_m3, w_m8, w_m14, w_m16 : input  word_t  - W[t-3], W[t-8], W[t-14], W[t-16]
//     w_new                    : output word_t  - W[t]
// ----------------------------------------------------------------------------
module sha1_new_block
    import sha1_msg_schedule_ctrl_pkg::*;
(
    input  word_t w_m3,
    input  word_t w_m8,
    input  word_t w_m14,
    input  word_t w_m16,
    output word_t w_new
);

    assign w_new = rotl1(w_m3 ^ w_m8 ^ w_m14 ^ w_m16);

endmodule

// File: rtl/sha1_msg_schedule_ctrl.sv
// ----------------------------------------------------------------------------
// sha1_msg_schedule_ctrl
//   SHA-1 message schedule sequencer. Loads 16 words of a 512-bit block into a
//   16-entry circular word buffer, then emits W[0..NUM_ROUNDS-1] one word per
//   output handshake. Words W[t], t>=16, are produced by sha1_new_block and
//   written back over the slot that held W[t-16] when accepted.
//
//   Parameters:
//     NUM_ROUNDS : words emitted per block (17..127)
//     BUF_DEPTH  : circular buffer depth, must be 16
//
//   Ports:
//     clk        in   system clock
//     reset_n    in   asynchronous active-low reset
//     start      in   begin a new block (honoured in IDLE only)
//     abort      in   synchronous abandon, back to IDLE on next edge
//     in_word    in   [31:0] message word, W[0] first
//     in_valid   in   in_word valid
//     in_ready   out  high in LOAD
//     out_word   out  [31:0] schedule word W[t] (0 outside RUN)
//     out_idx    out  [6:0] t of out_word (0 outside RUN)
//     out_valid  out  high in RUN
//     out_ready  in   consumer accepts out_word
//     stall_cnt  out  [15:0] saturating RUN stall counter
//                     (only when SHA1_SCHED_PERF_EN is defined)
//     busy       out  state != IDLE
//     done       out  one-cycle pulse after the last word is accepted
//
//   Optional feature macro: SHA1_SCHED_PERF_EN
// ----------------------------------------------------------------------------
module sha1_msg_schedule_ctrl
    import sha1_msg_schedule_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = SHA1_ROUNDS,
    parameter int BUF_DEPTH  = SHA1_WORDS_PER_BLOCK
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic [6:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef SHA1_SCHED_PERF_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        busy,
    output logic        done
);

    // Elaboration-time parameter sanity.
    generate
        if (NUM_ROUNDS < 17 || NUM_ROUNDS > 127) begin : g_bad_rounds
            $error("sha1_msg_schedule_ctrl: NUM_ROUNDS must be in 17..127");
        end
        if (BUF_DEPTH != 16) begin : g_bad_depth
            $error("sha1_msg_schedule_ctrl: BUF_DEPTH must be 16");
        end
    endgenerate

    localparam logic [6:0] LAST_IDX = 7'(NUM_ROUNDS - 1);

    sched_state_t state_reg, state_next;
    logic [6:0]   t_reg, t_next;
    logic         done_reg, done_next;
    logic         load_we, run_we;

    // Circular buffer: four combinational read taps, one write port.
    // Contents are not reset; every slot is rewritten during LOAD before use.
    word_t word_mem [16];

    logic [3:0] slot;
    logic [3:0] addr_m3, addr_m8, addr_m14;
    word_t      gen_word;
    word_t      cur_word;

    assign slot     = t_reg[3:0];
    assign addr_m3  = slot - 4'd3;
    assign addr_m8  = slot - 4'd8;
    assign addr_m14 = slot - 4'd14;

    // The slot at t&15 still holds W[t-16] until this word is accepted.
    sha1_new_block u_new_block (
        .w_m3  (word_mem[addr_m3]),
        .w_m8  (word_mem[addr_m8]),
        .w_m14 (word_mem[addr_m14]),
        .w_m16 (word_mem[slot]),
        .w_new (gen_word)
    );

    assign cur_word = (t_reg < 7'd16) ? word_mem[slot] : gen_word;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            t_reg     <= 7'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            done_reg  <= done_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // abort has priority in every state, including over start in IDLE and
    // over a handshake presented in the same cycle.
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        done_next  = 1'b0;
        load_we    = 1'b0;
        run_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!abort && start) begin
                    state_next = LOAD;
                    t_next     = 7'd0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                    t_next     = 7'd0;
                end else if (in_valid) begin
                    load_we = 1'b1;
                    if (slot == 4'd15) begin
                        state_next = RUN;
                        t_next     = 7'd0;
                    end else begin
                        t_next = t_reg + 7'd1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    t_next     = 7'd0;
                end else if (out_ready) begin
                    run_we = (t_reg >= 7'd16);
                    if (t_reg == LAST_IDX) begin
                        state_next = IDLE;
                        t_next     = 7'd0;
                        done_next  = 1'b1;
                    end else begin
                        t_next = t_reg + 7'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                t_next     = 7'd0;
            end
        endcase
    end

    // ---------------- buffer write port ----------------
    always_ff @(posedge clk) begin
        if (load_we) begin
            word_mem[slot] <= in_word;
        end else if (run_we) begin
            word_mem[slot] <= gen_word;
        end
    end

    // ---------------- outputs ----------------
    // Word and index are forced to zero outside RUN so every output reads 0
    // immediately after reset.
    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == RUN);
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign out_word  = out_valid ? cur_word : 32'd0;
    assign out_idx   = out_valid ? t_reg : 7'd0;

`ifdef SHA1_SCHED_PERF_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= 16'd0;
        end else if (state_reg == IDLE && start && !abort) begin
            stall_cnt_reg <= 16'd0;
        end else if (state_reg == RUN && !out_ready && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_sha1_msg_schedule_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sha1_msg_schedule_ctrl
//   Directed bench for sha1_msg_schedule_ctrl. Expected schedule words come
//   from the textbook SHA-1 recurrence over an 80-entry array, plus a few
//   hand-computed words for the "abc" block.
//   Optional feature macro: SHA1_SCHED_PERF_EN (adds stall_cnt checks).
// ----------------------------------------------------------------------------
module tb_sha1_msg_schedule_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] in_word = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_word;
    logic [6:0]  out_idx;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
`ifdef SHA1_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [80];

    always #5 clk = ~clk;

    sha1_msg_schedule_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHA1_SCHED_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic build_model();
        logic [31:0] x;
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 80; i++) begin
            x = exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16];
            exp_w[i] = {x[30:0], x[31]};
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_pattern(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) blk[i] = (seed * 32'(i + 1)) ^ {seed[15:0], seed[31:16]};
        build_model();
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in LOAD.
    task automatic do_start();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_in_ready", 32'(in_ready), 32'd1);
    endtask

    // Loads blk[0..nwords-1]; optional random gaps and a stray start pulse.
    task automatic load_block(input bit gaps, input int start_at, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            chk("load_ready", 32'(in_ready), 32'd1);
            chk("load_out_valid", 32'(out_valid), 32'd0);
            in_word  = blk[i];
            in_valid = 1'b1;
            start    = (i == start_at);
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        $display("load: %0d words accepted", nwords);
    endtask

    // Consumes the schedule, checking every cycle (stalls included).
    task automatic run_block(input bit stall, input int start_at, input int abort_at, input bit abc_hand);
        int idx;
        int stalls;
        int budget;
        bit rdy;
        idx = 0;
        stalls = 0;
        budget = 0;
        while (idx < 80 && budget < 2000) begin
            chk("run_valid", 32'(out_valid), 32'd1);
            chk("run_idx", 32'(out_idx), 32'(idx));
            chk("run_word", out_word, exp_w[idx]);
            if (abc_hand && idx == 16) chk("abc_w16", out_word, 32'hC2C4C700);
            if (abc_hand && idx == 17) chk("abc_w17", out_word, 32'h00000000);
            if (abc_hand && idx == 18) chk("abc_w18", out_word, 32'h00000030);
            if (idx == abort_at) begin
                abort     = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                abort     = 1'b0;
                out_ready = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_word", out_word, 32'd0);
                @(negedge clk);
                chk("abort_done_late", 32'(done), 32'd0);
                $display("run: aborted at t=%0d", idx);
                return;
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            start     = (idx == start_at);
            if (!rdy) stalls++;
            @(negedge clk);
            if (rdy) idx++;
            budget++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        if (budget >= 2000) chk("run_timeout", 32'(idx), 32'd80);
        chk("done_pulse", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
`ifdef SHA1_SCHED_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
        $display("run: %0d words, %0d stall cycles", idx, stalls);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        reset_n = 1'b1;

        // "abc" block, no stalls
        set_abc();
        do_start();
        load_block(1'b0, -1, 16);
        run_block(1'b0, -1, -1, 1'b1);

        // All-zero block
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        build_model();
        do_start();
        load_block(1'b0, -1, 16);
        run_block(1'b0, -1, -1, 1'b0);

        // Patterned block with input gaps, random backpressure and stray starts
        set_pattern(32'h9E3779B9);
        do_start();
        load_block(1'b1, 5, 16);
        run_block(1'b1, 30, -1, 1'b0);

        // Abort at t=40, then a clean "abc" block
        set_abc();
        do_start();
        load_block(1'b0, -1, 16);
        run_block(1'b0, -1, 40, 1'b1);
        do_start();
        load_block(1'b0, -1, 16);
        run_block(1'b0, -1, -1, 1'b1);

        // Async reset mid-LOAD at t=7
        set_pattern(32'hDEADBEEF);
        do_start();
        load_block(1'b0, -1, 7);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_word", out_word, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_abc();
        do_start();
        load_block(1'b0, -1, 16);
        run_block(1'b0, -1, -1, 1'b1);

        // start together with abort in IDLE: stays IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 32'd0);
        chk("start_abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("start_abort_busy2", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
